fp_addsub_issue: RTL and testbench

FP_ADDSUB_ISSUE -- requirements
Module: fp_addsub_issue

---
 rtl/fp_addsub_issue.sv | 148 ++++++++++++++
 tb/tb_fp_addsub_issue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_issue.sv
// fp_addsub_issue: issue/capture wrapper around an external combinational FP32 adder.
// Latches one A+B or A-B request, folds the subtraction into operand B's sign,
// resolves NaN/Inf operands locally, and otherwise waits SETTLE_CYCLES for the
// adder before capturing its result. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake (ready only while idle)
//   in_a, in_b, in_op      FP32 operands, op 0 = A+B, 1 = A-B
//   add_a, add_b           operands presented to the external adder (B sign-adjusted)
//   add_out                external adder result
//   out_valid/out_ready    result handshake
//   out_result, out_flags  FP32 result and {nan, inf, zero}
//   busy                   high whenever an operation is in progress
module fp_addsub_issue #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_op,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags,
    output logic        busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0]  SettleInit = 4'(SETTLE_CYCLES);
    localparam logic [31:0] QuietNan   = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;

    // Effective B operand: subtraction is a sign flip on B.
    logic [31:0] opb_in;
    logic        a_nan, a_inf, b_nan, b_inf;
    logic        add_nan, add_inf, add_zero;

    always_comb begin
        opb_in = {in_b[31] ^ in_op, in_b[30:0]};

        a_nan = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
        a_inf = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
        b_nan = (opb_in[30:23] == 8'hFF) && (opb_in[22:0] != 23'd0);
        b_inf = (opb_in[30:23] == 8'hFF) && (opb_in[22:0] == 23'd0);

        add_nan  = (add_out[30:23] == 8'hFF) && (add_out[22:0] != 23'd0);
        add_inf  = (add_out[30:23] == 8'hFF) && (add_out[22:0] == 23'd0);
        add_zero = (add_out[30:0] == 31'd0);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        flags_d  = flags_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    opa_d = in_a;
                    opb_d = opb_in;
                    if (a_nan || b_nan || (a_inf && b_inf && (in_a[31] != opb_in[31]))) begin
                        result_d = QuietNan;
                        flags_d  = 3'b100;
                        state_d  = StDone;
                    end else if (a_inf || b_inf) begin
                        // Equal-signed Inf+Inf takes A, which matches B anyway.
                        result_d = a_inf ? in_a : opb_in;
                        flags_d  = 3'b010;
                        state_d  = StDone;
                    end else begin
                        cnt_d   = SettleInit;
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = add_out;
                    flags_d  = {add_nan, add_inf, add_zero};
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            result_q <= 32'd0;
            flags_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StDone);
        busy       = (state_q != StIdle);
        add_a      = opa_q;
        add_b      = opb_q;
        out_result = result_q;
        out_flags  = flags_q;
    end

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Testbench for fp_addsub_issue: one instance with SETTLE_CYCLES=1 and one with 4,
// each driven by a small lookup adder model. Expected results go into a scoreboard
// queue at issue and are popped when the DUT presents out_valid.
module tb_fp_addsub_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_a, in_b;
    logic        in_op, out_ready;

    logic        in_valid1, in_ready1, out_valid1, busy1;
    logic [31:0] add_a1, add_b1, add_out1, out_result1;
    logic [2:0]  out_flags1;

    logic        in_valid4, in_ready4, out_valid4, busy4;
    logic [31:0] add_a4, add_b4, add_out4, out_result4;
    logic [2:0]  out_flags4;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;
    exp_t sb[$];

    fp_addsub_issue #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .add_a(add_a1), .add_b(add_b1),
        .add_out(add_out1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_result(out_result1), .out_flags(out_flags1), .busy(busy1)
    );

    fp_addsub_issue #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .add_a(add_a4), .add_b(add_b4),
        .add_out(add_out4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_result(out_result4), .out_flags(out_flags4), .busy(busy4)
    );

    // Lookup adder: only the operand pairs the bench uses.
    function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'hBF800000, 32'h3F800000}: return 32'h80000000;
            {32'h12345678, 32'h00000001}: return 32'h7FA00000;
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return 32'h7F800000;
            {32'h40400000, 32'hC0000000}: return 32'h3F800000;
            {32'h40000000, 32'h40400000}: return 32'h40A00000;
            default:                      return 32'h3F000000;
        endcase
    endfunction

    always_comb add_out1 = adder_model(add_a1, add_b1);
    always_comb add_out4 = adder_model(add_a4, add_b4);

    // Issue one request to the selected instance and wait (bounded) for out_valid.
    // lat counts clock edges from the accept edge to the first edge with out_valid high.
    task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] eres, input logic [2:0] eflg,
                        output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op;
        if (sel == 1) in_valid1 = 1'b1; else in_valid4 = 1'b1;
        sb.push_back({eres, eflg});
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        lat = 1;
        while (((sel == 1) ? out_valid1 : out_valid4) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid1 = 1'b1; in_valid4 = 1'b1; out_ready = 1'b0;
        in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_hs: got %b want 100100",
                     {in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4});
        end
        n_cmp++;
        if ({add_a1, add_b1, out_result1, out_flags1} !== 99'd0) begin
            n_fail++;
            $display("FAIL reset_regs: add_a=%h add_b=%h res=%h flags=%b want all 0",
                     add_a1, add_b1, out_result1, out_flags1);
        end
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy1, busy4, in_ready1} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_release: busy1,busy4,ready1=%b want 001",
                     {busy1, busy4, in_ready1});
        end
    endtask

    task automatic test_normal();
        logic [31:0] va [4] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h12345678};
        logic [31:0] vb [4] = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h00000001};
        logic        vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] vab[4] = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h00000001};
        logic [31:0] vr [4] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h7FA00000};
        logic [2:0]  vf [4] = '{3'b000, 3'b001, 3'b001, 3'b100};
        int lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(1, va[i], vb[i], vo[i], vr[i], vf[i], lat);
            e = sb.pop_front();
            n_cmp++;
            if (lat != 2) begin
                n_fail++; $display("FAIL normal_lat[%0d]: got %0d want 2", i, lat);
            end
            n_cmp++;
            if (add_a1 !== va[i] || add_b1 !== vab[i]) begin
                n_fail++;
                $display("FAIL normal_addab[%0d]: got %h/%h want %h/%h",
                         i, add_a1, add_b1, va[i], vab[i]);
            end
            n_cmp++;
            if (out_result1 !== e.res || out_flags1 !== e.flags) begin
                n_fail++;
                $display("FAIL normal_res[%0d]: got %h/%b want %h/%b",
                         i, out_result1, out_flags1, e.res, e.flags);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_cmp++;
            if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || add_b1 !== vab[i]) begin
                n_fail++;
                $display("FAIL normal_consume[%0d]: valid=%b ready=%b add_b=%h want 0 1 %h",
                         i, out_valid1, in_ready1, add_b1, vab[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [6] = '{32'h7F800000, 32'h7FC00000, 32'h3F800000,
                                32'hFF800000, 32'h7F800000, 32'h3F800000};
        logic [31:0] vb [6] = '{32'h7F800000, 32'h3F800000, 32'h7F800000,
                                32'h7F800000, 32'h3F800000, 32'hFF800001};
        logic        vo [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] vab[6] = '{32'hFF800000, 32'h3F800000, 32'hFF800000,
                                32'hFF800000, 32'h3F800000, 32'hFF800001};
        logic [31:0] vr [6] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                                32'hFF800000, 32'h7F800000, 32'h7FC00000};
        logic [2:0]  vf [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b100};
        int lat;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send(1, va[i], vb[i], vo[i], vr[i], vf[i], lat);
            e = sb.pop_front();
            n_cmp++;
            if (lat != 1) begin
                n_fail++; $display("FAIL special_lat[%0d]: got %0d want 1", i, lat);
            end
            n_cmp++;
            if (add_b1 !== vab[i]) begin
                n_fail++;
                $display("FAIL special_addb[%0d]: got %h want %h", i, add_b1, vab[i]);
            end
            n_cmp++;
            if (out_result1 !== e.res || out_flags1 !== e.flags) begin
                n_fail++;
                $display("FAIL special_res[%0d]: got %h/%b want %h/%b",
                         i, out_result1, out_flags1, e.res, e.flags);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_hold();
        int lat;
        int extra = 0;
        exp_t e;
        send(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat != 2 || out_result1 !== e.res || out_flags1 !== e.flags) begin
            n_fail++;
            $display("FAIL hold_res: lat=%0d res=%h flags=%b want 2 %h %b",
                     lat, out_result1, out_flags1, e.res, e.flags);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid1 = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
            end else begin
                in_valid1 = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if (out_result1 !== e.res || out_flags1 !== e.flags || out_valid1 !== 1'b1 ||
                in_ready1 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: res=%h flags=%b valid=%b ready=%b",
                         i, out_result1, out_flags1, out_valid1, in_ready1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (add_a1 !== 32'h7F7FFFFF || add_b1 !== 32'h7F7FFFFF) begin
            n_fail++;
            $display("FAIL hold_ignored_in: add_a=%h add_b=%h want 7f7fffff", add_a1, add_b1);
        end
        repeat (3) begin
            @(negedge clk);
            if (out_valid1 === 1'b1 || busy1 === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++; $display("FAIL hold_no_extra: got %0d busy cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] rdy_seen, vld_seen, busy_seen;
        int bad_res = 0;
        exp_t e;
        @(negedge clk);
        in_a = 32'h40400000; in_b = 32'h40000000; in_op = 1'b1;
        in_valid1 = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rdy_seen[8 - i]  = in_ready1;
            vld_seen[8 - i]  = out_valid1;
            busy_seen[8 - i] = busy1;
            if (in_ready1 === 1'b1) sb.push_back({32'h3F800000, 3'b000});
            if (out_valid1 === 1'b1) begin
                if (sb.size() == 0) begin
                    bad_res++;
                end else begin
                    e = sb.pop_front();
                    if (out_result1 !== e.res || out_flags1 !== e.flags) bad_res++;
                end
            end
            @(negedge clk);
        end
        in_valid1 = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (rdy_seen !== 9'b100100100) begin
            n_fail++; $display("FAIL b2b_ready: got %b want 100100100", rdy_seen);
        end
        n_cmp++;
        if (vld_seen !== 9'b001001001) begin
            n_fail++; $display("FAIL b2b_valid: got %b want 001001001", vld_seen);
        end
        n_cmp++;
        if (busy_seen !== 9'b011011011) begin
            n_fail++; $display("FAIL b2b_busy: got %b want 011011011", busy_seen);
        end
        n_cmp++;
        if (bad_res != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_results: bad=%0d left=%0d want 0 0", bad_res, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_settle_reset();
        int lat;
        int extra = 0;
        exp_t e;
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid4, in_ready4, busy4} !== 3'b010 || out_result4 !== 32'd0 ||
            add_b4 !== 32'd0) begin
            n_fail++;
            $display("FAIL settle_reset: valid,ready,busy=%b res=%h add_b=%h want 010 0 0",
                     {out_valid4, in_ready4, busy4}, out_result4, add_b4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid4 === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++; $display("FAIL settle_dropped: got %0d valid cycles want 0", extra);
        end
        send(4, 32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 3'b000, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat != 5) begin
            n_fail++; $display("FAIL settle4_lat: got %0d want 5", lat);
        end
        n_cmp++;
        if (out_result4 !== e.res || out_flags4 !== e.flags) begin
            n_fail++;
            $display("FAIL settle4_res: got %h/%b want %h/%b",
                     out_result4, out_flags4, e.res, e.flags);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL settle4_consume: valid=%b ready=%b want 0 1", out_valid4, in_ready4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_hold();
        test_back_to_back();
        test_settle_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
